// File: rtl/imem_pkg.sv
// Shared types for the instruction fetch path: FSM state names and the
// entry format carried through the fetch FIFO.
package imem_pkg;

    localparam int IMEM_ADDR_W = 10;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [31:0]            instr;
        logic [IMEM_ADDR_W-1:0] pc;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched words with their byte address.
// A flush empties it in one cycle and wins over push and pop.
module fetch_fifo
    import imem_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rstn,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             wdata,
    output fetch_entry_t             head,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    fetch_entry_t     store [DEPTH];
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;

    // Pointers and occupancy; DEPTH is a power of two so pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (!rstn || flush) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) wptr <= wptr + PTR_ONE;
            if (pop)  rptr <= rptr + PTR_ONE;
            case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
        end
    end

    // Storage is cleared on reset so the head reads as zero until the first fetch.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) store[i] <= '0;
        end else if (push && !flush) begin
            store[wptr] <= wdata;
        end
    end

    assign head = store[rptr];

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Fetch sequencer: owns the PC, requests words from a combinational-read
// instruction memory behind an arbiter, buffers them, and hands them to
// decode. Redirects flush the buffer and retarget the PC; halt drains it.
module imem_fetch_ctrl
    import imem_pkg::*;
#(
    parameter int                ADDR_W   = IMEM_ADDR_W,
    parameter int                DEPTH    = 2,
    parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              rstn,
    output logic              imem_req,
    input  logic              imem_gnt,
    output logic [31:0]       imem_addr,
    input  logic [31:0]       imem_rdata,
    input  logic              redir_valid,
    input  logic [ADDR_W-1:0] redir_pc,
    input  logic              halt_req,
    output logic              dec_valid,
    input  logic              dec_ready,
    output logic [31:0]       dec_instr,
    output logic [ADDR_W-1:0] dec_pc,
    output logic              halted,
    output logic              misalign_err
);

    localparam logic [1:0] ST_IDLE   = IDLE;
    localparam logic [1:0] ST_RUN    = RUN;
    localparam logic [1:0] ST_DRAIN  = DRAIN;
    localparam logic [1:0] ST_HALTED = HALTED;

    localparam int CNT_W = $clog2(DEPTH) + 1;
    localparam logic [CNT_W-1:0]  FULL    = CNT_W'(DEPTH);
    localparam logic [ADDR_W-1:0] PC_STEP = ADDR_W'(4);

    logic [1:0]        state;
    logic [1:0]        state_nxt;
    logic [ADDR_W-1:0] pc;
    logic [CNT_W-1:0]  count;
    logic              fetch_fire;
    logic              pop;
    fetch_entry_t      push_entry;
    fetch_entry_t      head;

    // The request only looks at registered occupancy, so decode readiness never reaches the memory port combinationally.
    assign imem_req   = (state == ST_RUN) && (count < FULL) && !halt_req;
    assign fetch_fire = imem_req && imem_gnt && !redir_valid;
    assign dec_valid  = (count != '0);
    assign pop        = dec_valid && dec_ready && !redir_valid;
    assign imem_addr  = {{(32-ADDR_W){1'b0}}, pc};
    assign dec_instr  = head.instr;
    assign dec_pc     = head.pc;
    assign halted     = (state == ST_HALTED);
    assign push_entry = '{instr: imem_rdata, pc: pc};

    fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rstn  (rstn),
        .push  (fetch_fire),
        .pop   (pop),
        .flush (redir_valid),
        .wdata (push_entry),
        .head  (head),
        .count (count)
    );

    // Next-state logic; a redirect while draining abandons the drain and parks the fetcher.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   state_nxt = ST_RUN;
            ST_RUN:    if (halt_req) state_nxt = ST_DRAIN;
            ST_DRAIN: begin
                if (redir_valid)       state_nxt = ST_HALTED;
                else if (!halt_req)    state_nxt = ST_RUN;
                else if (count == '0)  state_nxt = ST_HALTED;
            end
            ST_HALTED: if (redir_valid && !halt_req) state_nxt = ST_RUN;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rstn) state <= ST_IDLE;
        else       state <= state_nxt;
    end

    // PC: a redirect wins over the sequential advance; low bits are forced to word alignment.
    always_ff @(posedge clk) begin
        if (!rstn)            pc <= RESET_PC;
        else if (redir_valid) pc <= {redir_pc[ADDR_W-1:2], 2'b00};
        else if (fetch_fire)  pc <= pc + PC_STEP;
    end

    // Sticky flag for any redirect target that was not word aligned.
    always_ff @(posedge clk) begin
        if (!rstn)                                   misalign_err <= 1'b0;
        else if (redir_valid && (redir_pc[1:0] != 2'b00)) misalign_err <= 1'b1;
    end

endmodule

// File: tb/tb_imem_fetch_ctrl.sv
// Testbench for imem_fetch_ctrl: directed scenarios plus a randomized run,
// all compared against a queue-based reference model of the fetch path.
module tb_imem_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rstn;
    logic        imem_req;
    logic        imem_gnt;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        redir_valid;
    logic [9:0]  redir_pc;
    logic        halt_req;
    logic        dec_valid;
    logic        dec_ready;
    logic [31:0] dec_instr;
    logic [9:0]  dec_pc;
    logic        halted;
    logic        misalign_err;

    int checks = 0;
    int errors = 0;

    logic [7:0] mem [1024];

    // Reference model state
    typedef enum {M_BOOT, M_FETCH, M_DRAIN, M_STOP} mode_t;
    mode_t       m_mode;
    logic [9:0]  m_pc;
    logic        m_err;
    logic [31:0] q_instr [$];
    logic [9:0]  q_pc [$];

    always #5 clk = ~clk;

    imem_fetch_ctrl dut (
        .clk          (clk),
        .rstn         (rstn),
        .imem_req     (imem_req),
        .imem_gnt     (imem_gnt),
        .imem_addr    (imem_addr),
        .imem_rdata   (imem_rdata),
        .redir_valid  (redir_valid),
        .redir_pc     (redir_pc),
        .halt_req     (halt_req),
        .dec_valid    (dec_valid),
        .dec_ready    (dec_ready),
        .dec_instr    (dec_instr),
        .dec_pc       (dec_pc),
        .halted       (halted),
        .misalign_err (misalign_err)
    );

    // Big-endian word read from the byte memory
    function automatic logic [31:0] word_at(input logic [9:0] a);
        logic [9:0] b1, b2, b3;
        b1 = a + 10'd1;
        b2 = a + 10'd2;
        b3 = a + 10'd3;
        return {mem[a], mem[b1], mem[b2], mem[b3]};
    endfunction

    assign imem_rdata = word_at(imem_addr[9:0]);

    // Expected request from the model for the current inputs
    function automatic logic m_req();
        return (m_mode == M_FETCH) && (q_instr.size() < 2) && !halt_req;
    endfunction

    // Advance the model by one clock edge using the inputs held at that edge
    task automatic model_update();
        logic  req;
        logic  valid;
        mode_t nxt;
        if (!rstn) begin
            q_instr.delete();
            q_pc.delete();
            m_pc   = 10'd0;
            m_mode = M_BOOT;
            m_err  = 1'b0;
        end else begin
            req   = m_req();
            valid = (q_instr.size() != 0);
            nxt   = m_mode;
            case (m_mode)
                M_BOOT:  nxt = M_FETCH;
                M_FETCH: if (halt_req) nxt = M_DRAIN;
                M_DRAIN: begin
                    if (redir_valid)             nxt = M_STOP;
                    else if (!halt_req)          nxt = M_FETCH;
                    else if (q_instr.size() == 0) nxt = M_STOP;
                end
                M_STOP:  if (redir_valid && !halt_req) nxt = M_FETCH;
                default: nxt = m_mode;
            endcase
            m_mode = nxt;
            if (redir_valid) begin
                q_instr.delete();
                q_pc.delete();
                m_pc = redir_pc & 10'h3FC;
                if (redir_pc[1:0] != 2'b00) m_err = 1'b1;
            end else begin
                if (valid && dec_ready) begin
                    void'(q_instr.pop_front());
                    void'(q_pc.pop_front());
                end
                if (req && imem_gnt) begin
                    q_instr.push_back(word_at(m_pc));
                    q_pc.push_back(m_pc);
                    m_pc = m_pc + 10'd4;
                end
            end
        end
    endtask

    // One clock edge, model follows, then move away from the edge
    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    // Apply inputs for the coming cycle and let combinational outputs settle
    task automatic drive(input logic rv, input logic [9:0] rp, input logic h,
                         input logic g, input logic r);
        redir_valid = rv;
        redir_pc    = rp;
        halt_req    = h;
        imem_gnt    = g;
        dec_ready   = r;
        #1;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive(0, 10'd0, 0, 0, 0);
        step();
        rstn = 1'b1;
        drive(0, 10'd0, 0, 0, 0);
        step();
    endtask

    task automatic test_reset();
        rstn = 1'b0;
        drive(0, 10'd0, 0, 0, 0);
        step();
        step();
        drive(0, 10'd0, 0, 0, 0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL reset_req: got %b expected 0", imem_req); end
        checks++; if (imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL reset_addr: got %h expected 0", imem_addr); end
        checks++; if (dec_valid !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", dec_valid); end
        checks++; if (dec_instr !== 32'd0) begin errors++; $display("[TB] FAIL reset_instr: got %h expected 0", dec_instr); end
        checks++; if (dec_pc !== 10'd0) begin errors++; $display("[TB] FAIL reset_decpc: got %h expected 0", dec_pc); end
        checks++; if (halted !== 1'b0) begin errors++; $display("[TB] FAIL reset_halted: got %b expected 0", halted); end
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL reset_misalign: got %b expected 0", misalign_err); end
        rstn = 1'b1;
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL idle_req: got %b expected 0", imem_req); end
        step();
    endtask

    task automatic test_basic();
        logic [31:0] exp_w [3];
        exp_w[0] = 32'h8020000A;
        exp_w[1] = 32'h04400800;
        exp_w[2] = 32'h0C600800;
        do_reset();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL basic_first_req: got req=%b addr=%h expected req=1 addr=0", imem_req, imem_addr); end
        step();
        for (int i = 0; i < 3; i++) begin
            drive(0, 10'd0, 0, 1, 1);
            checks++;
            if (dec_valid !== 1'b1 || dec_instr !== exp_w[i] || dec_pc !== 10'(4*i)) begin
                errors++;
                $display("[TB] FAIL basic_word%0d: got v=%b instr=%h pc=%h expected v=1 instr=%h pc=%h", i, dec_valid, dec_instr, dec_pc, exp_w[i], 10'(4*i));
            end
            step();
        end
    endtask

    task automatic test_stall();
        do_reset();
        for (int i = 0; i < 5; i++) begin
            drive(0, 10'd0, 0, 1, 0);
            step();
        end
        drive(0, 10'd0, 0, 1, 0);
        checks++; if (imem_req !== 1'b0 || imem_addr !== 32'd8 || dec_valid !== 1'b1) begin errors++; $display("[TB] FAIL stall_full: got req=%b addr=%h v=%b expected req=0 addr=8 v=1", imem_req, imem_addr, dec_valid); end
        for (int i = 0; i < 3; i++) begin
            drive(0, 10'd0, 0, 1, 1);
            checks++;
            if (dec_valid !== 1'b1 || dec_pc !== 10'(4*i) || dec_instr !== word_at(10'(4*i))) begin
                errors++;
                $display("[TB] FAIL stall_drain%0d: got v=%b pc=%h instr=%h expected pc=%h instr=%h", i, dec_valid, dec_pc, dec_instr, 10'(4*i), word_at(10'(4*i)));
            end
            if (i == 1) begin
                checks++; if (imem_req !== 1'b1 || imem_addr !== 32'd8) begin errors++; $display("[TB] FAIL stall_resume: got req=%b addr=%h expected req=1 addr=8", imem_req, imem_addr); end
            end
            step();
        end
    endtask

    task automatic test_gnt_toggle();
        logic [9:0] next_pc;
        int delivered;
        next_pc = 10'd0;
        delivered = 0;
        do_reset();
        for (int i = 0; i < 12; i++) begin
            drive(0, 10'd0, 0, (i % 2) == 0, 1);
            checks++; if (imem_req !== m_req() || imem_addr !== {22'd0, m_pc}) begin errors++; $display("[TB] FAIL toggle_req%0d: got req=%b addr=%h expected req=%b addr=%h", i, imem_req, imem_addr, m_req(), m_pc); end
            if (dec_valid) begin
                checks++;
                if (dec_pc !== next_pc || dec_instr !== word_at(next_pc)) begin
                    errors++;
                    $display("[TB] FAIL toggle_seq%0d: got pc=%h instr=%h expected pc=%h instr=%h", i, dec_pc, dec_instr, next_pc, word_at(next_pc));
                end
                next_pc = next_pc + 10'd4;
                delivered++;
            end
            step();
        end
        drive(0, 10'd0, 0, 0, 1);
        checks++; if (delivered != 6 || imem_addr !== 32'd24) begin errors++; $display("[TB] FAIL toggle_total: got words=%0d addr=%h expected words=6 addr=18", delivered, imem_addr); end
    endtask

    task automatic test_redirect();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            drive(0, 10'd0, 0, 1, 0);
            step();
        end
        drive(0, 10'd0, 0, 1, 0);
        checks++; if (dec_valid !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL redir_prefull: got v=%b req=%b expected v=1 req=0", dec_valid, imem_req); end
        drive(1, 10'h100, 0, 1, 1);
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (dec_valid !== 1'b0 || imem_addr !== 32'h100 || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL redir_flush: got v=%b addr=%h req=%b expected v=0 addr=100 req=1", dec_valid, imem_addr, imem_req); end
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 10'h100 || dec_instr !== word_at(10'h100)) begin errors++; $display("[TB] FAIL redir_target: got v=%b pc=%h instr=%h expected pc=100 instr=%h", dec_valid, dec_pc, dec_instr, word_at(10'h100)); end
        step();
    endtask

    task automatic test_misalign();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (misalign_err !== 1'b0) begin errors++; $display("[TB] FAIL misalign_pre: got %b expected 0", misalign_err); end
        drive(1, 10'h102, 0, 1, 1);
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (imem_addr !== 32'h100 || misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL misalign_set: got addr=%h err=%b expected addr=100 err=1", imem_addr, misalign_err); end
        step();
        for (int i = 0; i < 4; i++) begin
            drive(i == 1, 10'h200, 0, 1, 1);
            checks++; if (misalign_err !== 1'b1) begin errors++; $display("[TB] FAIL misalign_sticky%0d: got %b expected 1", i, misalign_err); end
            step();
        end
    endtask

    task automatic test_wrap();
        drive(1, 10'h3FC, 0, 1, 1);
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (imem_addr !== 32'h3FC || imem_req !== 1'b1) begin errors++; $display("[TB] FAIL wrap_pre: got addr=%h req=%b expected addr=3fc req=1", imem_addr, imem_req); end
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (imem_addr !== 32'h0 || dec_pc !== 10'h3FC || dec_instr !== word_at(10'h3FC)) begin errors++; $display("[TB] FAIL wrap_post: got addr=%h pc=%h instr=%h expected addr=0 pc=3fc instr=%h", imem_addr, dec_pc, dec_instr, word_at(10'h3FC)); end
        step();
    endtask

    task automatic test_halt();
        int  popped;
        logic done;
        popped = 0;
        done = 1'b0;
        drive(1, 10'd0, 0, 1, 0);
        step();
        for (int i = 0; i < 2; i++) begin
            drive(0, 10'd0, 0, 1, 0);
            step();
        end
        drive(0, 10'd0, 1, 1, 0);
        checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halt_req_off: got %b expected 0", imem_req); end
        step();
        for (int i = 0; i < 8; i++) begin
            drive(0, 10'd0, 1, 1, 1);
            if (halted === 1'b1) begin
                done = 1'b1;
                break;
            end
            checks++; if (imem_req !== 1'b0) begin errors++; $display("[TB] FAIL drain_req%0d: got %b expected 0", i, imem_req); end
            if (dec_valid === 1'b1) begin
                checks++; if (dec_pc !== 10'(4*popped)) begin errors++; $display("[TB] FAIL drain_order: got pc=%h expected %h", dec_pc, 10'(4*popped)); end
                popped++;
            end
            step();
        end
        checks++; if (!done || popped != 2) begin errors++; $display("[TB] FAIL drain_halted: got halted=%b pops=%0d expected halted=1 pops=2", done, popped); end
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (halted !== 1'b1 || imem_req !== 1'b0) begin errors++; $display("[TB] FAIL halted_hold: got halted=%b req=%b expected halted=1 req=0", halted, imem_req); end
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (halted !== 1'b1) begin errors++; $display("[TB] FAIL halted_noredir: got %b expected 1", halted); end
        drive(1, 10'd0, 0, 1, 1);
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (halted !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'd0) begin errors++; $display("[TB] FAIL resume: got halted=%b req=%b addr=%h expected halted=0 req=1 addr=0", halted, imem_req, imem_addr); end
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 10'd0) begin errors++; $display("[TB] FAIL resume_word: got v=%b pc=%h expected v=1 pc=0", dec_valid, dec_pc); end
        step();
    endtask

    task automatic test_reset_mid();
        drive(1, 10'h40, 0, 1, 0);
        step();
        drive(0, 10'd0, 0, 1, 0);
        step();
        drive(0, 10'd0, 0, 0, 0);
        checks++; if (dec_valid !== 1'b1 || dec_pc !== 10'h40) begin errors++; $display("[TB] FAIL midrst_pre: got v=%b pc=%h expected v=1 pc=40", dec_valid, dec_pc); end
        rstn = 1'b0;
        drive(0, 10'd0, 0, 1, 1);
        step();
        drive(0, 10'd0, 0, 1, 1);
        checks++;
        if (dec_valid !== 1'b0 || imem_addr !== 32'd0 || misalign_err !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b0) begin
            errors++;
            $display("[TB] FAIL midrst_post: got v=%b addr=%h err=%b halted=%b req=%b expected all 0", dec_valid, imem_addr, misalign_err, halted, imem_req);
        end
        rstn = 1'b1;
        step();
    endtask

    task automatic test_random();
        logic h;
        h = 1'b0;
        do_reset();
        for (int i = 0; i < 600; i++) begin
            rstn = ($urandom_range(0, 199) != 0);
            if ($urandom_range(0, 19) == 0) h = ~h;
            drive($urandom_range(0, 11) == 0, 10'($urandom), h,
                  $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
            checks++; if (imem_req !== m_req()) begin errors++; $display("[TB] FAIL rnd_req@%0d: got %b expected %b", i, imem_req, m_req()); end
            checks++; if (imem_addr !== {22'd0, m_pc}) begin errors++; $display("[TB] FAIL rnd_addr@%0d: got %h expected %h", i, imem_addr, m_pc); end
            checks++; if (dec_valid !== (q_instr.size() != 0)) begin errors++; $display("[TB] FAIL rnd_valid@%0d: got %b expected %b", i, dec_valid, q_instr.size() != 0); end
            checks++; if (halted !== (m_mode == M_STOP)) begin errors++; $display("[TB] FAIL rnd_halted@%0d: got %b expected %b", i, halted, m_mode == M_STOP); end
            checks++; if (misalign_err !== m_err) begin errors++; $display("[TB] FAIL rnd_err@%0d: got %b expected %b", i, misalign_err, m_err); end
            if (q_instr.size() != 0) begin
                checks++;
                if (dec_instr !== q_instr[0] || dec_pc !== q_pc[0]) begin
                    errors++;
                    $display("[TB] FAIL rnd_head@%0d: got instr=%h pc=%h expected instr=%h pc=%h", i, dec_instr, dec_pc, q_instr[0], q_pc[0]);
                end
            end
            step();
        end
        rstn = 1'b1;
    endtask

    // Watchdog so a stuck run still ends with a report
    initial begin
        #1000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "[TB] timeout");
    end

    initial begin
        for (int i = 0; i < 1024; i++) mem[i] = 8'($urandom);
        mem[0]  = 8'h80; mem[1]  = 8'h20; mem[2]  = 8'h00; mem[3]  = 8'h0A;
        mem[4]  = 8'h04; mem[5]  = 8'h40; mem[6]  = 8'h08; mem[7]  = 8'h00;
        mem[8]  = 8'h0C; mem[9]  = 8'h60; mem[10] = 8'h08; mem[11] = 8'h00;
        rstn = 1'b0;
        m_mode = M_BOOT;
        m_pc = 10'd0;
        m_err = 1'b0;
        drive(0, 10'd0, 0, 0, 0);
        test_reset();
        test_basic();
        test_stall();
        test_gnt_toggle();
        test_redirect();
        test_misalign();
        test_wrap();
        test_halt();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
